// File: rtl/lvds_link_pkg.sv
// Shared definitions for the LVDS DDR transmit controller.
//   link_state_e      frame sequencer states
//   DIBIT_IDLE        dibit driven on the pad while no payload bits are sent
//   PREAMBLE_DEFAULT  sync byte sent ahead of every payload
package lvds_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    PRE,
    DATA,
    TRAIL
  } link_state_e;

  localparam logic [1:0] DIBIT_IDLE       = 2'b00;
  localparam logic [7:0] PREAMBLE_DEFAULT = 8'hD5;

endpackage

// File: rtl/lvds_ddr_tx_ctrl_if.sv
// Byte-stream handshake between a payload source and lvds_ddr_tx_ctrl.
//   s_valid  source -> sink  payload byte valid
//   s_data   source -> sink  payload byte
//   s_last   source -> sink  byte is the final byte of the frame
//   s_ready  sink -> source  byte accepted on this clk when s_valid & s_ready
interface lvds_ddr_tx_ctrl_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;

  modport master (output s_valid, output s_data, output s_last, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface

// File: rtl/lvds_dibit_serializer.sv
// Byte-to-dibit serializer: loads a byte and emits it MSB first, two bits per clk.
//   clk, rst    clock and asynchronous active-high reset
//   load        capture byte_in; its first dibit is on `dibit` next clk (highest priority)
//   clear       drive DIBIT_IDLE next clk and restart the dibit index
//   byte_in     byte to serialize
//   dibit       registered dibit: [1] rising-edge bit, [0] falling-edge bit
//   idx         index (0..3) of the dibit currently on `dibit`
//   last_dibit  high while the final dibit of the byte is on `dibit`
// With neither load nor clear asserted the register advances one dibit per clk.
module lvds_dibit_serializer
  import lvds_link_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clear,
  input  logic [7:0] byte_in,
  output logic [1:0] dibit,
  output logic [1:0] idx,
  output logic       last_dibit
);

  logic [7:0] sh_q, sh_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] dibit_q, dibit_d;

  always_comb begin
    sh_d    = sh_q;
    idx_d   = idx_q;
    dibit_d = dibit_q;
    if (load) begin
      dibit_d = byte_in[7:6];
      sh_d    = {byte_in[5:0], 2'b00};
      idx_d   = '0;
    end else if (clear) begin
      dibit_d = DIBIT_IDLE;
      sh_d    = '0;
      idx_d   = '0;
    end else begin
      dibit_d = sh_q[7:6];
      sh_d    = {sh_q[5:0], 2'b00};
      idx_d   = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q    <= '0;
      idx_q   <= '0;
      dibit_q <= '0;
    end else begin
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      dibit_q <= dibit_d;
    end
  end

  assign dibit      = dibit_q;
  assign idx        = idx_q;
  assign last_dibit = (idx_q == 2'd3);

endmodule

// File: rtl/lvds_ddr_tx_ctrl.sv
// Frame sequencer for one differential DDR output pad (SB_LVDS_OUTPUT / SB_LVDS_IO).
// Each frame: LEAD_CYCLES idle dibits, PREAMBLE byte, payload bytes, TRAIL_CYCLES idle
// dibits; the pad is released (OE=0) between frames for bus turnaround.
//   clk         single clock, also the pad's OUTPUT_CLK
//   rst         asynchronous active-high reset
//   s           byte-stream slave (s_valid/s_data/s_last in, s_ready out)
//   io_oe       pad OUTPUT_ENABLE (1 = drive pair)
//   io_clk_en   pad CLOCK_ENABLE
//   io_d_out_0  pad D_OUT_0, rising-edge bit
//   io_d_out_1  pad D_OUT_1, falling-edge bit
//   busy        high from frame start until OE is released
//   underrun    one-clk pulse when a frame is aborted for missing data
module lvds_ddr_tx_ctrl
  import lvds_link_pkg::*;
#(
  parameter int unsigned LEAD_CYCLES  = 2,
  parameter int unsigned TRAIL_CYCLES = 2,
  parameter logic [7:0]  PREAMBLE     = PREAMBLE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  lvds_ddr_tx_ctrl_if.slave   s,
  output logic                io_oe,
  output logic                io_clk_en,
  output logic                io_d_out_0,
  output logic                io_d_out_1,
  output logic                busy,
  output logic                underrun
);

  localparam logic [3:0] LEAD_LOAD  = 4'(LEAD_CYCLES - 1);
  localparam logic [3:0] TRAIL_LOAD = 4'(TRAIL_CYCLES - 1);

  link_state_e state_q, state_d;
  logic [3:0]  lt_cnt_q, lt_cnt_d;
  logic        last_q, last_d;
  logic        drive_q, drive_d;
  logic        ready_q, ready_d;
  logic        underrun_q, underrun_d;

  logic        ser_load, ser_clear;
  logic [7:0]  ser_byte;
  logic [1:0]  ser_dibit, ser_idx;
  logic        ser_last;

  lvds_dibit_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (ser_load),
    .clear      (ser_clear),
    .byte_in    (ser_byte),
    .dibit      (ser_dibit),
    .idx        (ser_idx),
    .last_dibit (ser_last)
  );

  always_comb begin
    state_d    = state_q;
    lt_cnt_d   = lt_cnt_q;
    last_d     = last_q;
    drive_d    = drive_q;
    ready_d    = 1'b0;
    underrun_d = 1'b0;
    ser_load   = 1'b0;
    ser_clear  = 1'b1;
    ser_byte   = PREAMBLE;
    unique case (state_q)
      IDLE: begin
        if (s.s_valid) begin
          state_d  = LEAD;
          lt_cnt_d = LEAD_LOAD;
          drive_d  = 1'b1;
        end
      end
      LEAD: begin
        if (lt_cnt_q == 4'd0) begin
          state_d  = PRE;
          ser_load = 1'b1;
        end else begin
          lt_cnt_d = lt_cnt_q - 4'd1;
        end
      end
      PRE, DATA: begin
        if (!ser_last) begin
          ser_clear = 1'b0;
          // ready is registered, so raise it one clk early to land on dibit 3
          ready_d = (ser_idx == 2'd2) && ((state_q == PRE) || !last_q);
        end else if (ready_q && s.s_valid) begin
          state_d  = DATA;
          ser_load = 1'b1;
          ser_byte = s.s_data;
          last_d   = s.s_last;
        end else begin
          state_d    = TRAIL;
          lt_cnt_d   = TRAIL_LOAD;
          underrun_d = !((state_q == DATA) && last_q);
        end
      end
      TRAIL: begin
        if (lt_cnt_q == 4'd0) begin
          state_d = IDLE;
          drive_d = 1'b0;
        end else begin
          lt_cnt_d = lt_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        drive_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lt_cnt_q   <= '0;
      last_q     <= 1'b0;
      drive_q    <= 1'b0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lt_cnt_q   <= lt_cnt_d;
      last_q     <= last_d;
      drive_q    <= drive_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
    end
  end

  assign s.s_ready  = ready_q;
  assign io_oe      = drive_q;
  assign io_clk_en  = drive_q;
  assign busy       = drive_q;
  assign underrun   = underrun_q;
  assign io_d_out_0 = ser_dibit[1];
  assign io_d_out_1 = ser_dibit[0];

endmodule

// File: tb/tb_lvds_ddr_tx_ctrl.sv
// Bench for lvds_ddr_tx_ctrl: two instances (default timing, and LEAD=1/TRAIL=15) share
// one stimulus source; `sel` picks the instance being checked. Each frame's expected pad
// trace is built from the frame description before it is driven.
module tb_lvds_ddr_tx_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       s_valid, s_last;
  logic [7:0] s_data;

  lvds_ddr_tx_ctrl_if bus_a();
  lvds_ddr_tx_ctrl_if bus_b();
  assign bus_a.s_valid = s_valid;
  assign bus_a.s_data  = s_data;
  assign bus_a.s_last  = s_last;
  assign bus_b.s_valid = s_valid;
  assign bus_b.s_data  = s_data;
  assign bus_b.s_last  = s_last;

  logic oe_a, ce_a, d0_a, d1_a, busy_a, ur_a;
  logic oe_b, ce_b, d0_b, d1_b, busy_b, ur_b;

  lvds_ddr_tx_ctrl #(.LEAD_CYCLES(2), .TRAIL_CYCLES(2), .PREAMBLE(8'hD5)) dut_a (
    .clk(clk), .rst(rst), .s(bus_a),
    .io_oe(oe_a), .io_clk_en(ce_a), .io_d_out_0(d0_a), .io_d_out_1(d1_a),
    .busy(busy_a), .underrun(ur_a)
  );

  lvds_ddr_tx_ctrl #(.LEAD_CYCLES(1), .TRAIL_CYCLES(15), .PREAMBLE(8'hD5)) dut_b (
    .clk(clk), .rst(rst), .s(bus_b),
    .io_oe(oe_b), .io_clk_en(ce_b), .io_d_out_0(d0_b), .io_d_out_1(d1_b),
    .busy(busy_b), .underrun(ur_b)
  );

  logic sel;
  int unsigned lead_n, trail_n;
  logic o_oe, o_ce, o_busy, o_ur, o_rdy;
  logic [1:0] o_dib;

  always_comb begin
    o_oe   = sel ? oe_b   : oe_a;
    o_ce   = sel ? ce_b   : ce_a;
    o_busy = sel ? busy_b : busy_a;
    o_ur   = sel ? ur_b   : ur_a;
    o_rdy  = sel ? bus_b.s_ready : bus_a.s_ready;
    o_dib  = sel ? {d0_b, d1_b} : {d0_a, d1_a};
  end

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic       oe;
    logic [1:0] dib;
    logic       rdy;
    logic       ur;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fb[$];   // payload bytes of the frame about to be sent
  int         frame_no = 0;

  function automatic logic [1:0] dibit_of(input logic [7:0] b, input int k);
    return 2'((b >> (6 - 2 * k)) & 8'h03);
  endfunction

  // Sends fb; drop_k >= 0 withholds bytes after drop_k have been accepted (underrun frame,
  // no byte carries last). keep_valid leaves s_valid high after the frame so the next
  // run_frame call starts back-to-back. Returns at the negedge of the released clk.
  task automatic run_frame(input int drop_k, input bit keep_valid);
    int  n, nsend, idx;
    bit  has_last, acc;
    n        = fb.size();
    has_last = (drop_k < 0);
    nsend    = has_last ? n : drop_k;
    frame_no++;

    exp_q.delete();
    for (int unsigned i = 0; i < lead_n; i++) exp_q.push_back('{1'b1, 2'b00, 1'b0, 1'b0});
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{1'b1, dibit_of(8'hD5, k), (k == 3), 1'b0});
    for (int i = 0; i < nsend; i++)
      for (int k = 0; k < 4; k++)
        exp_q.push_back('{1'b1, dibit_of(fb[i], k), (k == 3) && !(has_last && i == n - 1), 1'b0});
    for (int unsigned i = 0; i < trail_n; i++)
      exp_q.push_back('{1'b1, 2'b00, 1'b0, (i == 0) && !has_last});
    exp_q.push_back('{1'b0, 2'b00, 1'b0, 1'b0});

    s_valid = 1'b1;
    s_data  = (n > 0) ? fb[0] : 8'h00;
    s_last  = 1'b0;
    @(posedge clk);   // IDLE samples s_valid here; byte is not consumed
    idx = 0;
    acc = 1'b0;
    for (int j = 0; j < exp_q.size(); j++) begin
      #1;
      if (acc) idx++;
      acc = 1'b0;
      // garbage on data/last while not ready: only the accept edge may sample them
      s_valid = (idx < nsend) ? 1'b1 : keep_valid;
      s_data  = 8'($urandom);
      s_last  = 1'($urandom);
      @(negedge clk);
      check_eq($sformatf("f%0d.c%0d.oe", frame_no, j), 32'(o_oe), 32'(exp_q[j].oe));
      check_eq($sformatf("f%0d.c%0d.ce", frame_no, j), 32'(o_ce), 32'(exp_q[j].oe));
      check_eq($sformatf("f%0d.c%0d.busy", frame_no, j), 32'(o_busy), 32'(exp_q[j].oe));
      check_eq($sformatf("f%0d.c%0d.dibit", frame_no, j), 32'(o_dib), 32'(exp_q[j].dib));
      check_eq($sformatf("f%0d.c%0d.ready", frame_no, j), 32'(o_rdy), 32'(exp_q[j].rdy));
      check_eq($sformatf("f%0d.c%0d.underrun", frame_no, j), 32'(o_ur), 32'(exp_q[j].ur));
      if (s_valid && o_rdy && idx < nsend) begin
        s_data = fb[idx];
        s_last = has_last && (idx == n - 1);
        acc    = 1'b1;
      end
      if (j < exp_q.size() - 1) @(posedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst     = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int nb, dk;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    sel     = 1'b0;
    lead_n  = 2;
    trail_n = 2;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.oe", 32'(o_oe), 0);
    check_eq("rst.ce", 32'(o_ce), 0);
    check_eq("rst.busy", 32'(o_busy), 0);
    check_eq("rst.ready", 32'(o_rdy), 0);
    check_eq("rst.underrun", 32'(o_ur), 0);
    check_eq("rst.dibit", 32'(o_dib), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single byte A5 with last: 12 clks of OE, one ready pulse
    fb = {};
    fb.push_back(8'hA5);
    run_frame(-1, 1'b0);

    // three bytes, continuous payload
    fb = {};
    fb.push_back(8'h00); fb.push_back(8'hFF); fb.push_back(8'h3C);
    run_frame(-1, 1'b0);
    @(negedge clk);

    // underrun after the first byte
    fb = {};
    fb.push_back(8'hFF); fb.push_back(8'h12);
    run_frame(1, 1'b0);

    // underrun in the preamble
    run_frame(0, 1'b0);

    // back-to-back frames with s_valid held: one released clk between them
    fb = {};
    fb.push_back(8'h5A); fb.push_back(8'hC3);
    run_frame(-1, 1'b1);
    fb = {};
    fb.push_back(8'h81);
    run_frame(-1, 1'b0);

    // randomized frames
    for (int f = 0; f < 24; f++) begin
      nb = $urandom_range(1, 5);
      fb = {};
      for (int i = 0; i < nb; i++) fb.push_back(8'($urandom));
      dk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
      run_frame(dk, (dk < 0) && ($urandom_range(0, 2) == 0));
      if (!s_valid) repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // reset during byte 2 of a 4-byte frame
    s_valid = 1'b1;
    s_data  = 8'h6B;
    s_last  = 1'b0;
    @(posedge clk);
    repeat (lead_n + 10) @(posedge clk);
    #1;
    check_eq("midrst.oe_before", 32'(o_oe), 1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrst.oe", 32'(o_oe), 0);
    check_eq("midrst.ce", 32'(o_ce), 0);
    check_eq("midrst.busy", 32'(o_busy), 0);
    check_eq("midrst.dibit", 32'(o_dib), 0);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq($sformatf("postrst.c%0d.oe", c), 32'(o_oe), 0);
      check_eq($sformatf("postrst.c%0d.underrun", c), 32'(o_ur), 0);
    end
    fb = {};
    fb.push_back(8'hE7);
    run_frame(-1, 1'b0);

    // LEAD_CYCLES=1, TRAIL_CYCLES=15 instance
    pulse_reset();
    sel     = 1'b1;
    lead_n  = 1;
    trail_n = 15;
    @(negedge clk);
    fb = {};
    fb.push_back(8'h96); fb.push_back(8'h0F);
    run_frame(-1, 1'b0);
    fb = {};
    fb.push_back(8'h33); fb.push_back(8'h44);
    run_frame(1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
